// File: rtl/bypass_scoreboard_pkg.sv
// rtl/bypass_scoreboard_pkg.sv - shared entry type and register-address constants for the bypass scoreboard
package bypass_scoreboard_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_X0 = '0;

  typedef struct packed {
    logic                  valid;
    logic                  we;
    logic                  is_load;
    logic [REG_ADDR_W-1:0] rd;
  } sb_entry_t;

  localparam sb_entry_t SB_BUBBLE = '0;

  // x0 writes are architecturally discarded, so they never count as producers.
  function automatic logic is_producer(input sb_entry_t e);
    return e.valid && e.we && (e.rd != REG_X0);
  endfunction

endpackage

// File: rtl/bypass_scoreboard_if.sv
// rtl/bypass_scoreboard_if.sv - ID/EX/WB signal bundle between the pipeline and the bypass scoreboard
interface bypass_scoreboard_if #(
  parameter int XLEN       = 32,
  parameter int NUM_STAGES = 3
);
  import bypass_scoreboard_pkg::*;

  logic                       id_valid;
  logic                       id_we;
  logic                       id_is_load;
  logic [REG_ADDR_W-1:0]      id_rd;
  logic [REG_ADDR_W-1:0]      id_rs1;
  logic [REG_ADDR_W-1:0]      id_rs2;
  logic                       id_rs1_used;
  logic                       id_rs2_used;
  logic [XLEN-1:0]            rf_rdata1;
  logic [XLEN-1:0]            rf_rdata2;
  logic [NUM_STAGES*XLEN-1:0] stage_result;
  logic                       mem_hold;
  logic                       flush;
  logic                       id_stall;
  logic [XLEN-1:0]            ex_src1;
  logic [XLEN-1:0]            ex_src2;
  logic                       wb_we;
  logic [REG_ADDR_W-1:0]      wb_rd;
  logic [XLEN-1:0]            wb_data;

  modport master (
    output id_valid, id_we, id_is_load, id_rd, id_rs1, id_rs2,
           id_rs1_used, id_rs2_used, rf_rdata1, rf_rdata2,
           stage_result, mem_hold, flush,
    input  id_stall, ex_src1, ex_src2, wb_we, wb_rd, wb_data
  );

  modport slave (
    input  id_valid, id_we, id_is_load, id_rd, id_rs1, id_rs2,
           id_rs1_used, id_rs2_used, rf_rdata1, rf_rdata2,
           stage_result, mem_hold, flush,
    output id_stall, ex_src1, ex_src2, wb_we, wb_rd, wb_data
  );

endinterface

// File: rtl/bypass_scoreboard_bypass_mux.sv
// rtl/bypass_scoreboard_bypass_mux.sv - youngest-first operand selector from the registered EX select vector
module bypass_mux #(
  parameter int XLEN       = 32,
  parameter int NUM_STAGES = 3
) (
  input  logic [NUM_STAGES-1:0]      sel,
  input  logic [NUM_STAGES*XLEN-1:0] stage_result,
  input  logic [XLEN-1:0]            base,
  output logic [XLEN-1:0]            ex_src
);

  // Walk oldest to youngest so the lowest set index (youngest producer) wins.
  always_comb begin
    ex_src = base;
    for (int j = NUM_STAGES - 1; j >= 0; j--) begin
      if (sel[j]) ex_src = stage_result[j*XLEN +: XLEN];
    end
  end

endmodule

// File: rtl/bypass_scoreboard.sv
// rtl/bypass_scoreboard.sv - EX..WB destination tracking, operand forwarding, stalls and register-file write port
// Build option BYPASS_SCOREBOARD_FWD_EN: forward from younger stages; otherwise stall until the producer reaches WB.
module bypass_scoreboard
  import bypass_scoreboard_pkg::*;
#(
  parameter int XLEN             = 32,
  parameter int NUM_STAGES       = 3,
  parameter int LOAD_READY_STAGE = 2
) (
  input logic               clk,
  input logic               reset,
  bypass_scoreboard_if.slave sb
);

  localparam int LAST = NUM_STAGES - 1;

  sb_entry_t             ent [NUM_STAGES];
  sb_entry_t             id_entry;
  logic [LAST-1:0]       match1;
  logic [LAST-1:0]       match2;
  logic [LAST-1:0]       early_load;
  logic                  load_use;
  logic                  hazard;
  logic                  advance;
  logic                  wb_prod;
  logic [XLEN-1:0]       wb_data;
  logic [XLEN-1:0]       byp1;
  logic [XLEN-1:0]       byp2;
  logic [XLEN-1:0]       base1;
  logic [XLEN-1:0]       base2;
  logic [NUM_STAGES-1:0] sel1;
  logic [NUM_STAGES-1:0] sel2;

  // The last stage is excluded: its value reaches ID through the read bypass.
  always_comb begin
    match1     = '0;
    match2     = '0;
    early_load = '0;
    for (int j = 0; j < LAST; j++) begin
      early_load[j] = ent[j].is_load && (j + 1 < LOAD_READY_STAGE);
      match1[j]     = sb.id_rs1_used && is_producer(ent[j]) && (ent[j].rd == sb.id_rs1);
      match2[j]     = sb.id_rs2_used && is_producer(ent[j]) && (ent[j].rd == sb.id_rs2);
    end
  end

  assign load_use = |((match1 | match2) & early_load);

`ifdef BYPASS_SCOREBOARD_FWD_EN
  assign hazard = load_use;
`else
  logic alu_use;
  assign alu_use = |((match1 | match2) & ~early_load);
  assign hazard  = load_use | alu_use;
`endif

  assign sb.id_stall = sb.mem_hold || (hazard && sb.id_valid && !sb.flush);
  assign advance     = !sb.mem_hold;

  assign wb_data    = sb.stage_result[LAST*XLEN +: XLEN];
  assign wb_prod    = is_producer(ent[LAST]);
  assign sb.wb_we   = wb_prod;
  assign sb.wb_rd   = wb_prod ? ent[LAST].rd : REG_X0;
  assign sb.wb_data = wb_data;

  assign byp1 = (wb_prod && (ent[LAST].rd == sb.id_rs1)) ? wb_data : sb.rf_rdata1;
  assign byp2 = (wb_prod && (ent[LAST].rd == sb.id_rs2)) ? wb_data : sb.rf_rdata2;

  always_comb begin
    id_entry = SB_BUBBLE;
    if (sb.id_valid && !sb.id_stall && !sb.flush) begin
      id_entry.valid   = 1'b1;
      id_entry.we      = sb.id_we;
      id_entry.is_load = sb.id_is_load;
      id_entry.rd      = sb.id_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < NUM_STAGES; j++) ent[j] <= SB_BUBBLE;
      base1 <= '0;
      base2 <= '0;
    end else if (advance) begin
      ent[0] <= id_entry;
      for (int j = 1; j < NUM_STAGES; j++) ent[j] <= ent[j-1];
      base1 <= byp1;
      base2 <= byp2;
    end
  end

`ifdef BYPASS_SCOREBOARD_FWD_EN
  // A match against entry j is one stage older by the time the consumer sits in EX.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel1 <= '0;
      sel2 <= '0;
    end else if (advance) begin
      sel1 <= {match1, 1'b0};
      sel2 <= {match2, 1'b0};
    end
  end
`else
  assign sel1 = '0;
  assign sel2 = '0;
`endif

  bypass_mux #(.XLEN(XLEN), .NUM_STAGES(NUM_STAGES)) u_mux1 (
    .sel          (sel1),
    .stage_result (sb.stage_result),
    .base         (base1),
    .ex_src       (sb.ex_src1)
  );

  bypass_mux #(.XLEN(XLEN), .NUM_STAGES(NUM_STAGES)) u_mux2 (
    .sel          (sel2),
    .stage_result (sb.stage_result),
    .base         (base2),
    .ex_src       (sb.ex_src2)
  );

endmodule

// File: tb/tb_bypass_scoreboard.sv
// tb/tb_bypass_scoreboard.sv - cycle-table bench for bypass_scoreboard with an EX-operand scoreboard queue
module tb_bypass_scoreboard;

  localparam int XLEN = 32;
  localparam int NS   = 3;

  typedef struct packed {
    logic        valid, we, is_load;
    logic [4:0]  rd, rs1, rs2;
    logic        u1, u2;
    logic [31:0] rf1, rf2, sr0, sr1, sr2;
    logic        hold, flush, exp_stall;
    logic        chk_ex;
    logic [31:0] e1, e2;
    logic        chk_wb, wb_we;
    logic [4:0]  wb_rd;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  vec_t tbl[$];
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  bypass_scoreboard_if #(.XLEN(XLEN), .NUM_STAGES(NS)) sb ();

  bypass_scoreboard #(.XLEN(XLEN), .NUM_STAGES(NS), .LOAD_READY_STAGE(2)) dut (
    .clk   (clk),
    .reset (reset),
    .sb    (sb)
  );

  function automatic vec_t nop();
    vec_t v;
    v = '0;
    return v;
  endfunction

  function automatic vec_t ins(input int we, input int ld, input int rd, input int rs1, input int rs2);
    vec_t v;
    v = '0;
    v.valid = 1'b1; v.we = (we != 0); v.is_load = (ld != 0);
    v.rd = 5'(rd); v.rs1 = 5'(rs1); v.rs2 = 5'(rs2);
    v.u1 = 1'b1; v.u2 = 1'b1;
    return v;
  endfunction

  function automatic vec_t rf(input vec_t v, input logic [31:0] a, input logic [31:0] b);
    v.rf1 = a; v.rf2 = b;
    return v;
  endfunction

  function automatic vec_t srv(input vec_t v, input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    v.sr0 = a; v.sr1 = b; v.sr2 = c;
    return v;
  endfunction

  function automatic vec_t ex(input vec_t v, input logic [31:0] a, input logic [31:0] b);
    v.chk_ex = 1'b1; v.e1 = a; v.e2 = b;
    return v;
  endfunction

  function automatic vec_t wb(input vec_t v, input int we, input int rd);
    v.chk_wb = 1'b1; v.wb_we = (we != 0); v.wb_rd = 5'(rd);
    return v;
  endfunction

  function automatic vec_t st(input vec_t v);
    v.exp_stall = 1'b1;
    return v;
  endfunction

  function automatic vec_t hl(input vec_t v);
    v.hold = 1'b1; v.exp_stall = 1'b1;
    return v;
  endfunction

  task automatic add(input vec_t v);
    tbl.push_back(v);
  endtask

  task automatic drain();
    repeat (3) add(nop());
  endtask

  task automatic drive(input vec_t v);
    sb.id_valid     = v.valid;
    sb.id_we        = v.we;
    sb.id_is_load   = v.is_load;
    sb.id_rd        = v.rd;
    sb.id_rs1       = v.rs1;
    sb.id_rs2       = v.rs2;
    sb.id_rs1_used  = v.u1;
    sb.id_rs2_used  = v.u2;
    sb.rf_rdata1    = v.rf1;
    sb.rf_rdata2    = v.rf2;
    sb.stage_result = {v.sr2, v.sr1, v.sr0};
    sb.mem_hold     = v.hold;
    sb.flush        = v.flush;
  endtask

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h want %h", name, row, act, exp);
    end
  endtask

  task automatic build_table();
    vec_t v;
    drain();
`ifdef BYPASS_SCOREBOARD_FWD_EN
    // dependent ALU pair, both operands from the same producer in MEM
    add(ex(ins(1, 0, 1, 0, 0), 0, 0));
    v = rf(ins(1, 0, 4, 1, 1), 32'h99, 32'h98);
    add(ex(v, 32'h5, 32'h5));
    add(srv(nop(), 32'h66, 32'h5, 32'h77));
    drain();
    // two producers of x1: the younger one wins
    add(ex(ins(1, 0, 1, 0, 0), 0, 0));
    add(ex(ins(1, 0, 1, 0, 0), 0, 0));
    add(ex(rf(ins(1, 0, 4, 1, 0), 32'h99, 0), 32'hB1, 0));
    add(srv(nop(), 32'hA0, 32'hB1, 32'hB2));
    drain();
    // load-use: one stall, one bubble, then data from stage 2
    add(ex(ins(1, 1, 2, 0, 0), 0, 0));
    v = rf(ins(1, 0, 5, 0, 2), 32'h7, 32'h99);
    add(st(v));
    add(ex(v, 32'h7, 32'hDEADBEEF));
    add(wb(srv(nop(), 32'h2, 32'h1, 32'hDEADBEEF), 1, 2));
    add(wb(nop(), 0, 0));
    add(wb(nop(), 1, 5));
    drain();
    // mem_hold for 3 cycles with the consumer waiting in ID
    add(ex(ins(1, 0, 1, 0, 0), 0, 0));
    v = rf(ins(1, 0, 4, 1, 0), 32'h99, 0);
    repeat (3) add(hl(v));
    add(ex(v, 32'h5, 0));
    add(srv(nop(), 32'h66, 32'h5, 32'h77));
    drain();
`else
    // dependent ALU pair: two stalls, then WB read bypass
    add(ex(ins(1, 0, 1, 0, 0), 0, 0));
    v = rf(ins(1, 0, 4, 1, 1), 32'h99, 32'h98);
    add(st(v));
    add(st(v));
    add(wb(ex(srv(v, 0, 0, 32'h12345678), 32'h12345678, 32'h12345678), 1, 1));
    add(srv(nop(), 0, 0, 32'hFFFF));
    drain();
    // load followed by consumer on rs2
    add(ex(ins(1, 1, 2, 0, 0), 0, 0));
    v = rf(ins(1, 0, 5, 0, 2), 32'h7, 32'h99);
    add(st(v));
    add(st(v));
    add(wb(ex(srv(v, 0, 0, 32'hDEADBEEF), 32'h7, 32'hDEADBEEF), 1, 2));
    add(nop());
    drain();
    // mem_hold for 3 cycles in the middle of the dependency stall
    add(ex(ins(1, 0, 1, 0, 0), 0, 0));
    v = rf(ins(1, 0, 4, 1, 0), 32'h99, 0);
    add(st(v));
    repeat (3) add(hl(v));
    add(st(v));
    add(wb(ex(srv(v, 0, 0, 32'h3C), 32'h3C, 0), 1, 1));
    add(nop());
    drain();
`endif
    // distance 3: producer in WB, ID read bypass
    add(ex(ins(1, 0, 3, 0, 0), 0, 0));
    add(ex(ins(1, 0, 6, 0, 0), 0, 0));
    add(ex(ins(1, 0, 7, 0, 0), 0, 0));
    add(wb(ex(srv(rf(ins(1, 0, 8, 3, 0), 0, 32'h21), 0, 0, 32'hAA), 32'hAA, 32'h21), 1, 3));
    add(srv(nop(), 0, 0, 32'h5));
    drain();
    // x0 producer never matches and never writes back
    add(ex(ins(1, 0, 0, 0, 0), 0, 0));
    add(ex(srv(ins(1, 0, 9, 0, 0), 32'h55, 32'h55, 32'h55), 0, 0));
    add(srv(nop(), 32'h55, 32'h55, 32'h55));
    add(wb(nop(), 0, 0));
    add(wb(nop(), 1, 9));
    drain();
    // operand field matches but is not read
    add(ex(ins(1, 0, 1, 0, 0), 0, 0));
    v = rf(ins(1, 0, 4, 1, 0), 32'h42, 0);
    v.u1 = 1'b0;
    add(ex(v, 32'h42, 0));
    add(srv(nop(), 32'h11, 32'h11, 32'h11));
    drain();
    // flush overrides a pending load-use and the squashed instruction never writes back
    add(ex(ins(1, 1, 2, 0, 0), 0, 0));
    v = ins(1, 0, 9, 0, 2);
    v.flush = 1'b1;
    add(v);
    add(nop());
    add(wb(nop(), 1, 2));
    add(wb(nop(), 0, 0));
    drain();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] e;
    reset = 1'b1;
    drive(srv(nop(), 32'h11, 32'h11, 32'h11));
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_id_stall", -1, 32'(sb.id_stall), 0);
    chk("rst_ex_src1", -1, sb.ex_src1, 0);
    chk("rst_ex_src2", -1, sb.ex_src2, 0);
    chk("rst_wb_we", -1, 32'(sb.wb_we), 0);
    chk("rst_wb_rd", -1, 32'(sb.wb_rd), 0);

    // reset mid-stream discards an in-flight producer of x1
    @(posedge clk); #1;
    reset = 1'b0;
    drive(ins(1, 0, 1, 0, 0));
    @(posedge clk); #1;
    reset = 1'b1;
    drive(srv(ins(1, 0, 4, 1, 1), 32'h11, 32'h11, 32'h11));
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_id_stall", -2, 32'(sb.id_stall), 0);
    chk("midrst_ex_src1", -2, sb.ex_src1, 0);
    chk("midrst_wb_we", -2, 32'(sb.wb_we), 0);

    build_table();
    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk); #1;
      drive(tbl[i]);
      @(negedge clk);
      chk("id_stall", i, 32'(sb.id_stall), 32'(tbl[i].exp_stall));
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("ex_src1", i, sb.ex_src1, e[63:32]);
        chk("ex_src2", i, sb.ex_src2, e[31:0]);
      end
      if (tbl[i].chk_wb) begin
        chk("wb_we", i, 32'(sb.wb_we), 32'(tbl[i].wb_we));
        chk("wb_rd", i, 32'(sb.wb_rd), 32'(tbl[i].wb_rd));
        if (tbl[i].wb_we) chk("wb_data", i, sb.wb_data, tbl[i].sr2);
      end
      if (tbl[i].chk_ex) exp_q.push_back({tbl[i].e1, tbl[i].e2});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
